// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between fetch_unit and imem: request/response packets with
// valid/ready handshakes. master = fetch side, slave = memory side.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        MemRead  = 2'd0,
        MemWrite = 2'd1
    } mem_type_e;

    typedef struct packed {
        mem_type_e   mtype;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_pkt_t;

endpackage

interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic     req_vld;
    logic     req_rdy;
    mem_pkt_t req;
    logic     rsp_vld;
    logic     rsp_rdy;
    mem_pkt_t rsp;

    modport master (
        output req_vld,
        output req,
        output rsp_rdy,
        input  req_rdy,
        input  rsp_vld,
        input  rsp
    );

    modport slave (
        input  req_vld,
        input  req,
        input  rsp_rdy,
        output req_rdy,
        output rsp_vld,
        output rsp
    );

endinterface

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-checked imem request issue, in-order instruction
// queue towards D, and redirect with discard of responses still in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       N_BITS          = 32,
    parameter int unsigned       FQ_DEPTH        = 4,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter logic [N_BITS-1:0] RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_vld,
    input  logic [N_BITS-1:0] redirect_pc,
    fetch_unit_if.master      imem,
    output logic              instr_vld,
    input  logic              instr_rdy,
    output logic [N_BITS-1:0] instr,
    output logic [N_BITS-1:0] instr_pc,
    output logic [N_BITS-1:0] instr_pc_plus4
);

    localparam int unsigned       OW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned       CW     = $clog2(FQ_DEPTH + 1);
    localparam int unsigned       PW     = $clog2(FQ_DEPTH);
    localparam int unsigned       SW     = ((OW > CW) ? OW : CW) + 1;
    localparam logic [OW-1:0]     MaxOut = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0]     FqCap  = SW'(FQ_DEPTH);
    localparam logic [N_BITS-1:0] PcStep = N_BITS'(4);
    localparam logic [N_BITS-1:0] PcMask = ~N_BITS'(3);

    logic [N_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [N_BITS-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [OW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     fq_count_q, fq_count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [N_BITS-1:0] fq_instr_q [FQ_DEPTH];
    logic [N_BITS-1:0] fq_instr_d [FQ_DEPTH];
    logic [N_BITS-1:0] fq_pc_q    [FQ_DEPTH];
    logic [N_BITS-1:0] fq_pc_d    [FQ_DEPTH];

    logic [OW-1:0] live;
    logic [SW-1:0] credit_used;
    logic          req_fire, rsp_fire, rsp_drop, push, pop;
    logic          unused_rsp_fields;

    assign unused_rsp_fields = ^{imem.rsp.mtype, imem.rsp.addr, imem.rsp.len};

    // Credit covers queued entries plus responses that will be kept; registered state only.
    always_comb begin
        live         = outst_q - drop_q;
        credit_used  = SW'(live) + SW'(fq_count_q);
        imem.req_vld = rst_n && !redirect_vld && (outst_q < MaxOut) && (credit_used < FqCap);
        imem.rsp_rdy = 1'b1;
        imem.req     = '{mtype: MemRead, addr: fetch_pc_q, len: 2'b00, data: '0};

        instr_vld      = (fq_count_q != '0) && !redirect_vld;
        instr          = fq_instr_q[rd_ptr_q];
        instr_pc       = fq_pc_q[rd_ptr_q];
        instr_pc_plus4 = fq_pc_q[rd_ptr_q] + PcStep;
    end

    always_comb begin
        req_fire = imem.req_vld && imem.req_rdy;
        rsp_fire = imem.rsp_vld && (outst_q != '0);
        rsp_drop = rsp_fire && (drop_q != '0);
        push     = rsp_fire && !rsp_drop && !redirect_vld;
        pop      = instr_vld && instr_rdy;

        outst_d = outst_q;
        if (req_fire) outst_d = outst_d + OW'(1);
        if (rsp_fire) outst_d = outst_d - OW'(1);

        drop_d     = rsp_drop ? drop_q - OW'(1) : drop_q;
        fetch_pc_d = req_fire ? fetch_pc_q + PcStep : fetch_pc_q;
        rsp_pc_d   = push ? rsp_pc_q + PcStep : rsp_pc_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

        fq_count_d = fq_count_q;
        if (push) fq_count_d = fq_count_d + CW'(1);
        if (pop)  fq_count_d = fq_count_d - CW'(1);

        fq_instr_d = fq_instr_q;
        fq_pc_d    = fq_pc_q;
        if (push) begin
            fq_instr_d[wr_ptr_q] = imem.rsp.data;
            fq_pc_d[wr_ptr_q]    = rsp_pc_q;
        end

        // Everything still in flight after this cycle's accounting becomes stale.
        if (redirect_vld) begin
            fetch_pc_d = redirect_pc & PcMask;
            rsp_pc_d   = redirect_pc & PcMask;
            drop_d     = outst_d;
            fq_count_d = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            fq_count_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                fq_instr_q[i] <= '0;
                fq_pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            fq_count_q <= fq_count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fq_instr_q <= fq_instr_d;
            fq_pc_q    <= fq_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable latency and an
// in-order scoreboard of expected fetch and delivered PCs.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_vld = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_vld;
    logic        instr_rdy = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    fetch_unit_if bus ();

    fetch_unit #(
        .N_BITS          (32),
        .FQ_DEPTH        (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_vld   (redirect_vld),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .instr_vld      (instr_vld),
        .instr_rdy      (instr_rdy),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    pend_t       pend[$];
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req_addr = RESET_PC;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Sample this cycle's handshakes mid-cycle, then advance and drive the memory response.
    task automatic cycle();
        pend_t p;
        @(negedge clk);
        if (bus.req_vld) check("req_addr", bus.req.addr, exp_req_addr);
        if (instr_vld && instr_rdy) begin
            check("pop_pc", instr_pc, exp_pc);
            check("pop_instr", instr, instr_of(exp_pc));
            check("pop_pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_vld) begin
            exp_req_addr = redirect_pc & ~32'd3;
            exp_pc       = redirect_pc & ~32'd3;
        end else if (bus.req_vld && bus.req_rdy) begin
            pend.push_back('{addr: bus.req.addr, due: cyc + mem_lat});
            exp_req_addr = exp_req_addr + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.rsp_vld = 1'b0;
        bus.rsp     = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            bus.rsp_vld   = 1'b1;
            bus.rsp.data  = instr_of(p.addr);
        end
    endtask

    task automatic wait_vld(input string tag, input int max_cycles);
        int n = 0;
        while (!instr_vld && n < max_cycles) begin
            cycle();
            n++;
        end
        check(tag, instr_vld, 1);
    endtask

    task automatic find_quiet_stream(input string tag);
        int found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (instr_vld && bus.rsp_vld && pend.size() == 0) found = 1;
            else cycle();
        end
        check(tag, found, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] head;
        logic [31:0] stall_addr;
        int          found;

        bus.req_rdy = 1'b0;
        bus.rsp_vld = 1'b0;
        bus.rsp     = '0;
        #2 rst_n = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_vld", bus.req_vld, 0);
        check("rst_instr_vld", instr_vld, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_pc_plus4", instr_pc_plus4, 32'd4);
        check("rst_rsp_rdy", bus.rsp_rdy, 1);

        // Streaming fill with 1-cycle memory
        bus.req_rdy = 1'b1;
        instr_rdy   = 1'b1;
        rst_n       = 1'b1;
        cyc         = 0;
        #1;
        check("first_req_vld", bus.req_vld, 1);
        check("first_req_addr", bus.req.addr, RESET_PC);
        check("req_mtype", bus.req.mtype, MemRead);
        check("req_len", bus.req.len, 0);
        check("req_data", bus.req.data, 0);
        check("fill_c0_vld", instr_vld, 0);
        cycle();
        check("fill_c1_vld", instr_vld, 0);
        cycle();
        check("fill_c2_vld", instr_vld, 1);
        check("fill_c2_pc", instr_pc, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("stream_vld", instr_vld, 1);
        end

        // D back-pressure: queue saturates, then drains in order
        instr_rdy = 1'b0;
        repeat (10) cycle();
        check("hold_instr_vld", instr_vld, 1);
        check("hold_req_vld", bus.req_vld, 0);
        check("hold_head_pc", instr_pc, exp_pc);
        head      = exp_pc;
        instr_rdy = 1'b1;
        #1;
        check("rel0_req_vld", bus.req_vld, 0);
        for (int i = 0; i < 4; i++) begin
            check("rel_vld", instr_vld, 1);
            check("rel_pc", instr_pc, head + 32'(4 * i));
            if (i == 1) begin
                check("rel1_req_vld", bus.req_vld, 1);
                check("rel1_req_addr", bus.req.addr, head + 32'd16);
            end
            cycle();
        end
        repeat (4) cycle();

        // imem back-pressure: address held while not accepted
        bus.req_rdy = 1'b0;
        #1;
        stall_addr = exp_req_addr;
        for (int i = 0; i < 3; i++) begin
            check("stall_req_vld", bus.req_vld, 1);
            check("stall_addr", bus.req.addr, stall_addr);
            cycle();
        end
        bus.req_rdy = 1'b1;
        repeat (6) cycle();

        // Slow memory, two in flight, redirect to misaligned target
        mem_lat = 3;
        found   = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (pend.size() == 2 && !bus.rsp_vld) found = 1;
            else cycle();
        end
        check("rd1_two_inflight", found, 1);
        redirect_vld = 1'b1;
        redirect_pc  = 32'h103;
        #1;
        check("rd1_t0_instr_vld", instr_vld, 0);
        check("rd1_t0_req_vld", bus.req_vld, 0);
        cycle();
        redirect_vld = 1'b0;
        #1;
        check("rd1_t1_instr_vld", instr_vld, 0);
        check("rd1_t1_req_vld", bus.req_vld, 0);
        check("rd1_t1_addr", bus.req.addr, 32'h100);
        wait_vld("rd1_wait_vld", 20);
        check("rd1_first_pc", instr_pc, 32'h100);
        check("rd1_first_instr", instr, instr_of(32'h100));
        mem_lat = 1;
        repeat (10) cycle();

        // Redirect colliding with a pop and a response
        find_quiet_stream("rd2_found");
        redirect_vld = 1'b1;
        redirect_pc  = 32'h200;
        #1;
        check("rd2_t0_instr_vld", instr_vld, 0);
        cycle();
        redirect_vld = 1'b0;
        #1;
        check("rd2_t1_instr_vld", instr_vld, 0);
        check("rd2_t1_req_vld", bus.req_vld, 1);
        check("rd2_t1_addr", bus.req.addr, 32'h200);
        cycle();
        check("rd2_t2_instr_vld", instr_vld, 0);
        cycle();
        check("rd2_t3_instr_vld", instr_vld, 1);
        check("rd2_t3_pc", instr_pc, 32'h200);
        repeat (4) cycle();

        // Address wrap at the top of the space
        find_quiet_stream("wrap_found");
        redirect_vld = 1'b1;
        redirect_pc  = 32'hFFFF_FFFE;
        cycle();
        redirect_vld = 1'b0;
        wait_vld("wrap_wait_vld", 10);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", instr_pc_plus4, 32'h0);
        cycle();
        wait_vld("wrap_wait_vld2", 10);
        check("wrap_next_pc", instr_pc, 32'h0);
        repeat (3) cycle();

        // Asynchronous reset with three queued entries, then a stray response
        instr_rdy = 1'b0;
        repeat (8) cycle();
        check("full_req_vld", bus.req_vld, 0);
        instr_rdy = 1'b1;
        cycle();
        instr_rdy = 1'b0;
        #1;
        check("q3_instr_vld", instr_vld, 1);
        check("q3_req_vld", bus.req_vld, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_instr_vld", instr_vld, 0);
        check("arst_req_vld", bus.req_vld, 0);
        check("arst_instr", instr, 0);
        check("arst_instr_pc", instr_pc, 0);
        check("arst_pc_plus4", instr_pc_plus4, 32'd4);
        pend.delete();
        bus.rsp_vld  = 1'b0;
        bus.rsp      = '0;
        bus.req_rdy  = 1'b0;
        instr_rdy    = 1'b1;
        exp_pc       = RESET_PC;
        exp_req_addr = RESET_PC;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        #1;
        check("rel_req_vld", bus.req_vld, 1);
        check("rel_req_addr", bus.req.addr, RESET_PC);
        bus.rsp_vld  = 1'b1;
        bus.rsp.data = 32'hDEAD_BEEF;
        cycle();
        check("stray_s1_instr_vld", instr_vld, 0);
        bus.req_rdy = 1'b1;
        cycle();
        check("stray_s2_instr_vld", instr_vld, 0);
        cycle();
        check("stray_s3_instr_vld", instr_vld, 1);
        check("stray_s3_pc", instr_pc, RESET_PC);
        check("stray_s3_instr", instr, instr_of(RESET_PC));
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
